// File: rtl/cls_pkg.sv
// Shared definitions for the wide sequential subtractor: FSM states,
// slice width and the index-counter width helper.
package cls_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cls_state_e;

    localparam int SLICE_W = 16;

    // Width of the slice index; a single-slice build still needs one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/CLS_16bit.sv
// 16-bit carry-lookahead subtractor slice. Borrow generate/propagate are
// formed per bit, combined per nibble, and the nibble borrows are resolved
// by lookahead. Group generate/propagate are exported so the caller can
// chain slices with bout = gg | (gp & bin).
import cls_pkg::*;

module CLS_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        bin_i,
    output logic [15:0] d_o,
    output logic        gg_o,
    output logic        gp_o
);

    // Bit and nibble borrow lookahead, difference bits and group terms.
    always_comb begin
        logic [15:0] g_v;
        logic [15:0] p_v;
        logic [3:0]  ng_v;
        logic [3:0]  np_v;
        logic [4:0]  nc_v;
        logic [16:0] c_v;
        logic        gg_v;
        logic        gp_v;
        g_v  = ~a_i & b_i;
        p_v  = ~(a_i ^ b_i);
        ng_v = 4'b0000;
        np_v = 4'b0000;
        nc_v = 5'b00000;
        c_v  = 17'b0;
        gg_v = 1'b0;
        gp_v = 1'b1;
        for (int n = 0; n < 4; n++) begin
            ng_v[n] = 1'b0;
            np_v[n] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                ng_v[n] = g_v[4*n+k] | (p_v[4*n+k] & ng_v[n]);
                np_v[n] = np_v[n] & p_v[4*n+k];
            end
        end
        nc_v[0] = bin_i;
        for (int n = 0; n < 4; n++) begin
            nc_v[n+1] = ng_v[n] | (np_v[n] & nc_v[n]);
            gg_v      = ng_v[n] | (np_v[n] & gg_v);
            gp_v      = gp_v & np_v[n];
        end
        for (int n = 0; n < 4; n++) begin
            c_v[4*n] = nc_v[n];
            for (int k = 0; k < 4; k++) begin
                c_v[4*n+k+1] = g_v[4*n+k] | (p_v[4*n+k] & c_v[4*n+k]);
            end
        end
        d_o  = a_i ^ b_i ^ c_v[15:0];
        gg_o = gg_v;
        gp_o = gp_v;
    end

endmodule

// File: rtl/cls_seq_wide.sv
// Wide subtractor sequencer: accepts 16*WORDS-bit operands, subtracts one
// 16-bit slice per cycle (LSB first) through CLS_16bit with the borrow
// chained in a register, then presents diff/bout until accepted.
// Optional zero/ovf flags are built when CLS_SEQ_FLAGS_EN is defined.
import cls_pkg::*;

module cls_seq_wide #(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLICE_W*WORDS-1:0] in_a,
    input  logic [SLICE_W*WORDS-1:0] in_b,
    input  logic                   bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE_W*WORDS-1:0] diff,
    output logic                   bout
`ifdef CLS_SEQ_FLAGS_EN
    ,
    output logic                   zero,
    output logic                   ovf
`endif
);

    localparam int W  = SLICE_W * WORDS;
    localparam int IW = idx_width(WORDS);

    cls_state_e        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              brw_q, brw_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      diff_q, diff_d;
    logic              bout_q, bout_d;
`ifdef CLS_SEQ_FLAGS_EN
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
`endif

    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic [SLICE_W-1:0] slice_d_s;
    logic               slice_gg_s;
    logic               slice_gp_s;
    logic               slice_bout_s;

    assign slice_a_s    = a_q[SLICE_W*idx_q +: SLICE_W];
    assign slice_b_s    = b_q[SLICE_W*idx_q +: SLICE_W];
    assign slice_bout_s = slice_gg_s | (slice_gp_s & brw_q);

    CLS_16bit u_cls (
        .a_i   (slice_a_s),
        .b_i   (slice_b_s),
        .bin_i (brw_q),
        .d_o   (slice_d_s),
        .gg_o  (slice_gg_s),
        .gp_o  (slice_gp_s)
    );

    // Handshake flags decode from state and are held low during reset.
    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign out_valid = (state_q == ST_DONE) & ~rst;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef CLS_SEQ_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif

    // Next-state: operand capture, per-slice update, result hand-off.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        brw_d   = brw_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef CLS_SEQ_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    brw_d   = bin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                diff_d[SLICE_W*idx_q +: SLICE_W] = slice_d_s;
                brw_d = slice_bout_s;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(WORDS - 1)) begin
                    state_d = ST_DONE;
                    bout_d  = slice_bout_s;
`ifdef CLS_SEQ_FLAGS_EN
                    zero_d  = (diff_d == '0);
                    ovf_d   = (a_q[W-1] != b_q[W-1]) & (diff_d[W-1] != a_q[W-1]);
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand, borrow and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef CLS_SEQ_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            brw_q   <= brw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef CLS_SEQ_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_cls_seq_wide.sv
// Directed bench for cls_seq_wide (WORDS=4): results are predicted by a
// wide-arithmetic model into a queue at handshake time and popped when
// out_valid is expected. Flag checks are built with CLS_SEQ_FLAGS_EN.
module tb_cls_seq_wide;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef CLS_SEQ_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    cls_seq_wide #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CLS_SEQ_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation; hold = cycles of backpressure in DONE (with
    // in_valid pulsed), hold==0 raises out_ready early during RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input int hold);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.zero = (full[W-1:0] == {W{1'b0}});
        e.ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        sb_q.push_back(e);

        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        bin       = bi;
        out_ready = (hold == 0);
        chk("hs_in_ready", W'(in_ready), W'(1'b1));
        step();
        in_valid = 1'b0;
        in_a     = {$urandom(), $urandom()};
        in_b     = {$urandom(), $urandom()};
        bin      = 1'($urandom());
        for (int c = 1; c <= WORDS; c++) begin
            chk("run_in_ready", W'(in_ready), W'(1'b0));
            chk("run_out_valid", W'(out_valid), W'(1'b0));
            step();
        end
        chk("lat_out_valid", W'(out_valid), W'(1'b1));
        e = sb_q.pop_front();
        chk("diff", diff, e.diff);
        chk("bout", W'(bout), W'(e.bout));
`ifdef CLS_SEQ_FLAGS_EN
        chk("zero", W'(zero), W'(e.zero));
        chk("ovf", W'(ovf), W'(e.ovf));
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = {$urandom(), $urandom()};
            in_b     = {$urandom(), $urandom()};
            step();
            chk("bp_out_valid", W'(out_valid), W'(1'b1));
            chk("bp_in_ready", W'(in_ready), W'(1'b0));
            chk("bp_diff", diff, e.diff);
            chk("bp_bout", W'(bout), W'(e.bout));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_in_ready", W'(in_ready), W'(1'b1));
        chk("post_out_valid", W'(out_valid), W'(1'b0));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", W'(in_ready), W'(1'b0));
        chk("rst_out_valid", W'(out_valid), W'(1'b0));
        chk("rst_diff", diff, '0);
        chk("rst_bout", W'(bout), W'(1'b0));
        rst = 1'b0;
        #1;
        chk("rel_in_ready", W'(in_ready), W'(1'b1));

        // Full borrow ripple across all slices.
        run_op(64'h0, 64'h1, 1'b0, 0);
        // Borrow crossing three slices plus borrow-in.
        run_op(64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 0);
        // Backpressure with in_valid pulsed while DONE.
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 3);
        // Equal operands with borrow-in gives all ones and borrow.
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);

        // Reset while RUN is on slice index 2.
        in_valid = 1'b1;
        in_a     = 64'hDEAD_BEEF_0000_1111;
        in_b     = 64'h0000_0000_2222_3333;
        bin      = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_out_valid", W'(out_valid), W'(1'b0));
        chk("abort_in_ready", W'(in_ready), W'(1'b1));
        chk("abort_diff", diff, '0);
        for (int c = 0; c < WORDS + 2; c++) begin
            step();
            chk("abort_no_pulse", W'(out_valid), W'(1'b0));
        end
        run_op(64'd100, 64'd58, 1'b0, 0);

        // Random operands.
        for (int r = 0; r < 4; r++) begin
            run_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()), r % 2);
        end

`ifdef CLS_SEQ_FLAGS_EN
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
